// File: rtl/multiply_tokens_if.sv
// Token stream bundle for multiply_tokens: one-bit input stream plus
// the expanded output stream and its status.
interface multiply_tokens_if #(
  parameter int unsigned PENDING_MAX = 15
);
  localparam int unsigned PW = $clog2(PENDING_MAX + 1);

  logic          a;
  logic          b;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  // Producer side: drives tokens in, observes the expanded stream.
  modport master (
    output a,
    input  b,
    input  busy,
    input  pending,
    input  overflow
  );

  // Multiplier side.
  modport slave (
    input  a,
    output b,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/multiply_tokens.sv
// Serial token multiplier: each '1' on a yields FACTOR '1's on b, at most
// one per cycle. The tokens that are not yet sent wait in a saturating
// pending counter. The overflow flag is sticky and records any dropped
// tokens.
module multiply_tokens #(
  parameter int unsigned FACTOR      = 2,   // 1..8
  parameter int unsigned PENDING_MAX = 15   // >= FACTOR-1
) (
  input  logic            clk,
  input  logic            rst,
  multiply_tokens_if.slave tok
);
  localparam int unsigned CW = $clog2(PENDING_MAX + 1);
  localparam int unsigned NW = $clog2(PENDING_MAX + FACTOR + 1);

  logic [CW-1:0] cnt;
  logic          ovf;
  logic          b_int;
  logic [NW-1:0] nxt;

  // Emit a token now if one arrives or any are queued. The count is
  // evaluated wide so that it cannot wrap before saturation. It cannot
  // underflow: b=1 with cnt=0 implies a=1.
  always_comb begin
    b_int = rst & (tok.a | (cnt != '0));
    nxt   = NW'(cnt)
          + (tok.a ? NW'(FACTOR) : NW'(0))
          - (b_int ? NW'(1)      : NW'(0));
  end

  // Pending counter with saturation and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (nxt > NW'(PENDING_MAX)) begin
      cnt <= CW'(PENDING_MAX);
      ovf <= 1'b1;
    end else begin
      cnt <= nxt[CW-1:0];
    end
  end

  assign tok.b        = b_int;
  assign tok.busy     = (cnt != '0);
  assign tok.pending  = cnt;
  assign tok.overflow = ovf;
endmodule

// File: tb/tb_multiply_tokens.sv
// Bench for multiply_tokens: four configurations share one clock and reset.
// The directed scenarios use fixed expected sequences. The random traffic
// is compared against a saturating-count reference model.
module tb_multiply_tokens;
  localparam int FAC [4] = '{1, 2, 3, 2};
  localparam int PMX [4] = '{15, 15, 15, 3};

  logic clk;
  logic rst;
  logic clr;
  logic [3:0] av;

  multiply_tokens_if #(.PENDING_MAX(15)) if1 ();
  multiply_tokens_if #(.PENDING_MAX(15)) if2 ();
  multiply_tokens_if #(.PENDING_MAX(15)) if3 ();
  multiply_tokens_if #(.PENDING_MAX(3))  ifs ();

  assign if1.a = av[0];
  assign if2.a = av[1];
  assign if3.a = av[2];
  assign ifs.a = av[3];

  multiply_tokens #(.FACTOR(1), .PENDING_MAX(15)) u1 (.clk(clk), .rst(rst), .tok(if1));
  multiply_tokens #(.FACTOR(2), .PENDING_MAX(15)) u2 (.clk(clk), .rst(rst), .tok(if2));
  multiply_tokens #(.FACTOR(3), .PENDING_MAX(15)) u3 (.clk(clk), .rst(rst), .tok(if3));
  multiply_tokens #(.FACTOR(2), .PENDING_MAX(3))  us (.clk(clk), .rst(rst), .tok(ifs));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic       ob_b [4];
  logic       ob_busy [4];
  logic       ob_ovf [4];
  logic [7:0] ob_p [4];

  always_comb begin
    ob_b[0] = if1.b; ob_b[1] = if2.b; ob_b[2] = if3.b; ob_b[3] = ifs.b;
    ob_busy[0] = if1.busy; ob_busy[1] = if2.busy; ob_busy[2] = if3.busy; ob_busy[3] = ifs.busy;
    ob_ovf[0] = if1.overflow; ob_ovf[1] = if2.overflow; ob_ovf[2] = if3.overflow; ob_ovf[3] = ifs.overflow;
    ob_p[0] = 8'(if1.pending); ob_p[1] = 8'(if2.pending); ob_p[2] = 8'(if3.pending); ob_p[3] = 8'(ifs.pending);
  end

  // Reference model: outstanding-token count with saturation and a sticky drop flag.
  int m_cnt [4];
  bit m_ovf [4];
  int cnt_a [4];
  int cnt_b [4];

  function automatic logic mb(int i);
    return rst && (av[i] || m_cnt[i] != 0);
  endfunction

  function automatic int model_next(int i);
    return m_cnt[i] + (av[i] ? FAC[i] : 0) - (mb(i) ? 1 : 0);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst) begin
        m_cnt[i] <= 0;
        m_ovf[i] <= 1'b0;
      end else if (model_next(i) > PMX[i]) begin
        m_cnt[i] <= PMX[i];
        m_ovf[i] <= 1'b1;
      end else begin
        m_cnt[i] <= model_next(i);
      end
      if (clr) begin
        cnt_a[i] <= 0;
        cnt_b[i] <= 0;
      end else if (rst) begin
        cnt_a[i] <= cnt_a[i] + int'(av[i]);
        cnt_b[i] <= cnt_b[i] + int'(ob_b[i]);
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    av  = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #2;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ob_b[i] !== 1'b0) begin
          errors++;
          $display("FAIL reset_b dut%0d cycle %0d: got %b want 0", i, c, ob_b[i]);
        end
      end
      tick();
    end
    av  = 4'b0000;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ob_p[i] !== 8'd0 || ob_busy[i] !== 1'b0 || ob_ovf[i] !== 1'b0) begin
          errors++;
          $display("FAIL reset_state dut%0d: got pending=%0d busy=%b ovf=%b want 0/0/0",
                   i, ob_p[i], ob_busy[i], ob_ovf[i]);
        end
      end
      #2;
      checks++;
      if (if2.b !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle_b: got %b want 0", if2.b);
      end
      tick();
    end
  endtask

  task automatic test_doubling();
    logic [7:0] pa = 8'b1100_0000;
    logic [7:0] pb = 8'b1111_0000;
    int ep [8] = '{1, 2, 1, 0, 0, 0, 0, 0};
    for (int c = 0; c < 8; c++) begin
      av = 4'b0000;
      av[1] = pa[7-c];
      #2;
      checks++;
      if (if2.b !== pb[7-c]) begin
        errors++;
        $display("FAIL doubling_b cycle %0d: got %b want %b", c, if2.b, pb[7-c]);
      end
      tick();
      checks++;
      if (if2.pending !== 4'(ep[c]) || if2.overflow !== 1'b0) begin
        errors++;
        $display("FAIL doubling_pending cycle %0d: got %0d ovf=%b want %0d ovf=0",
                 c, if2.pending, if2.overflow, ep[c]);
      end
    end
  endtask

  task automatic test_interleaved();
    logic [7:0] pa = 8'b1010_1000;
    logic [7:0] pb = 8'b1111_1100;
    int ntok = 0;
    for (int c = 0; c < 8; c++) begin
      av = 4'b0000;
      av[1] = pa[7-c];
      #2;
      ntok += int'(if2.b);
      checks++;
      if (if2.b !== pb[7-c]) begin
        errors++;
        $display("FAIL interleaved_b cycle %0d: got %b want %b", c, if2.b, pb[7-c]);
      end
      tick();
      if (c >= 5) begin
        checks++;
        if (if2.busy !== 1'b0) begin
          errors++;
          $display("FAIL interleaved_busy cycle %0d: got %b want 0", c, if2.busy);
        end
      end
    end
    checks++;
    if (ntok != 6) begin
      errors++;
      $display("FAIL interleaved_count: got %0d want 6", ntok);
    end
  endtask

  task automatic test_factor_three();
    logic [4:0] pa = 5'b10000;
    logic [4:0] pb = 5'b11100;
    int ep [5] = '{2, 1, 0, 0, 0};
    for (int c = 0; c < 5; c++) begin
      av = 4'b0000;
      av[2] = pa[4-c];
      #2;
      checks++;
      if (if3.b !== pb[4-c]) begin
        errors++;
        $display("FAIL factor3_b cycle %0d: got %b want %b", c, if3.b, pb[4-c]);
      end
      tick();
      checks++;
      if (if3.pending !== 4'(ep[c])) begin
        errors++;
        $display("FAIL factor3_pending cycle %0d: got %0d want %0d", c, if3.pending, ep[c]);
      end
    end
  endtask

  task automatic test_saturation();
    int ep [10] = '{1, 2, 3, 3, 3, 3, 2, 1, 0, 0};
    int ntok = 0;
    for (int c = 0; c < 10; c++) begin
      av = 4'b0000;
      av[3] = (c < 6);
      #2;
      ntok += int'(ifs.b);
      checks++;
      if (ifs.b !== (c < 9)) begin
        errors++;
        $display("FAIL sat_b cycle %0d: got %b want %b", c, ifs.b, (c < 9));
      end
      tick();
      checks++;
      if (ifs.pending !== 2'(ep[c]) || ifs.overflow !== (c >= 3)) begin
        errors++;
        $display("FAIL sat_state cycle %0d: got pending=%0d ovf=%b want pending=%0d ovf=%b",
                 c, ifs.pending, ifs.overflow, ep[c], (c >= 3));
      end
    end
    checks++;
    if (ntok != 9) begin
      errors++;
      $display("FAIL sat_count: got %0d want 9", ntok);
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int c = 0; c < 3; c++) begin
      av = 4'b0010;
      tick();
    end
    checks++;
    if (if2.pending !== 4'd3) begin
      errors++;
      $display("FAIL middrain_fill: got %0d want 3", if2.pending);
    end
    av  = 4'b0000;
    rst = 1'b0;
    #2;
    checks++;
    if (if2.b !== 1'b0) begin
      errors++;
      $display("FAIL middrain_b_in_reset: got %b want 0", if2.b);
    end
    tick();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (if2.pending !== 4'd0 || if2.overflow !== 1'b0) begin
        errors++;
        $display("FAIL middrain_state cycle %0d: got pending=%0d ovf=%b want 0/0",
                 c, if2.pending, if2.overflow);
      end
      #2;
      checks++;
      if (if2.b !== 1'b0) begin
        errors++;
        $display("FAIL middrain_b cycle %0d: got %b want 0", c, if2.b);
      end
      tick();
    end
  endtask

  task automatic test_factor_one();
    for (int c = 0; c < 20; c++) begin
      av = 4'b0000;
      av[0] = 1'($urandom_range(0, 1));
      #2;
      checks++;
      if (if1.b !== av[0]) begin
        errors++;
        $display("FAIL factor1_b cycle %0d: got %b want %b", c, if1.b, av[0]);
      end
      tick();
      checks++;
      if (if1.busy !== 1'b0 || if1.overflow !== 1'b0 || if1.pending !== 4'd0) begin
        errors++;
        $display("FAIL factor1_state cycle %0d: got busy=%b ovf=%b pending=%0d want 0/0/0",
                 c, if1.busy, if1.overflow, if1.pending);
      end
    end
  endtask

  task automatic test_random();
    int drained;
    clr = 1'b1;
    av  = 4'b0000;
    tick();
    clr = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (i == 3 && c >= 100 && c < 120) av[i] = 1'b1;
        else av[i] = ($urandom_range(0, 2) == 0);
      end
      #2;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ob_b[i] !== mb(i)) begin
          errors++;
          $display("FAIL rand_b dut%0d cycle %0d: got %b want %b", i, c, ob_b[i], mb(i));
        end
      end
      tick();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ob_p[i] !== 8'(m_cnt[i]) || ob_busy[i] !== (m_cnt[i] != 0) || ob_ovf[i] !== m_ovf[i]) begin
          errors++;
          $display("FAIL rand_state dut%0d cycle %0d: got p=%0d busy=%b ovf=%b want p=%0d busy=%b ovf=%b",
                   i, c, ob_p[i], ob_busy[i], ob_ovf[i], m_cnt[i], (m_cnt[i] != 0), m_ovf[i]);
        end
      end
    end
    av = 4'b0000;
    drained = 0;
    for (int k = 0; k < 40 && drained == 0; k++) begin
      if (!ob_busy[0] && !ob_busy[1] && !ob_busy[2] && !ob_busy[3]) drained = 1;
      else tick();
    end
    checks++;
    if (drained == 0) begin
      errors++;
      $display("FAIL drain_timeout: got busy=%b%b%b%b want 0000",
               ob_busy[3], ob_busy[2], ob_busy[1], ob_busy[0]);
    end
    checks++;
    if (ifs.overflow !== 1'b1) begin
      errors++;
      $display("FAIL rand_sat_overflow: got %b want 1", ifs.overflow);
    end
    for (int i = 0; i < 3; i++) begin
      if (!m_ovf[i]) begin
        checks++;
        if (cnt_b[i] != FAC[i] * cnt_a[i]) begin
          errors++;
          $display("FAIL conservation dut%0d: got %0d out tokens want %0d",
                   i, cnt_b[i], FAC[i] * cnt_a[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    clr = 1'b0;
    av  = 4'b0000;
    tick();
    test_reset();
    test_doubling();
    test_interleaved();
    test_factor_three();
    test_saturation();
    test_reset_mid_drain();
    test_factor_one();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multiply_tokens.md
# multiply_tokens

Serial token multiplier: every '1' token on input `a` produces FACTOR '1' tokens on output `b`, at most one per cycle. Tokens that cannot be emitted immediately are queued in a saturating pending counter. The block is the expansion counterpart of the serial token-halving stage and sits on the same one-bit-per-cycle token streams. It is used to rebalance token rates between producer and consumer stages.

## Interface

- `FACTOR`, 2, output tokens per input token; legal range 1..8.
- `PENDING_MAX`, 15, pending-counter capacity; must be ≥ FACTOR-1.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset; one clock; synchronous, active-low (`rst`=0 resets).
- `a`  input  1  incoming token stream; '1' = token.
- `b`  output  1  outgoing token stream; '1' = token.
- `busy`  output  1  1 when the pending counter is non-zero.
- `pending`  output  $clog2(PENDING_MAX+1)  current pending-token count.
- `overflow`  output  1  sticky flag: at least one token was dropped since reset.

## Operation

- State: `pending` counter (cnt) and `overflow` flag. No other state.
- Output token decision, combinational in the current cycle: `b` = `rst` & (`a` | (cnt != 0)).
- Count update each cycle when `rst`=1: next = cnt + (`a` ? FACTOR : 0) - (`b` ? 1 : 0).
  - Evaluate at width $clog2(PENDING_MAX+FACTOR+1) to avoid wrap.
- Saturation: if next > PENDING_MAX, cnt ← PENDING_MAX and `overflow` ← 1. Excess tokens are discarded.
- `overflow` stays 1 until reset. Input `a` never clears it.
- `busy` = (cnt != 0). `pending` = cnt. Both are registered-state outputs.
- FACTOR=1: cnt never leaves 0. `b` equals `a` exactly, `busy`=0, `overflow`=0.
- Simultaneous input token and pending drain in the same cycle:
  - Exactly one output token is emitted.
  - The count changes by FACTOR-1.
- Token conservation without overflow: total '1's on `b` = FACTOR × total '1's on `a`, once `busy` returns to 0.

## Timing

- Reset (`rst`=0 at a rising edge): cnt ← 0, `overflow` ← 0.
  - While `rst`=0, `b` is forced to 0 combinationally.
  - Reset values: `b`=0, `busy`=0, `pending`=0, `overflow`=0.
- Reset mid-operation: all queued tokens are discarded. No tokens emitted after release until the next `a`=1.
- Latency: the first output token appears in the same cycle as its input token (0 cycles).
  - The remaining FACTOR-1 tokens follow on consecutive cycles unless later tokens are queued ahead of them.
- Drain: with `a`=0, `b`=1 for exactly cnt consecutive cycles, then 0. cnt decrements by 1 per cycle.
- Saturation boundary:
  - cnt = PENDING_MAX and `a`=1 → `b`=1, cnt stays PENDING_MAX, `overflow` rises on that edge.
  - cnt + FACTOR - 1 = PENDING_MAX exactly → no overflow.
- `overflow` and `pending` change only on rising edges. `b` may change combinationally with `a`.

## Test plan

- Reset/idle: hold `rst`=0 for 3 cycles with `a`=1.
  - Required: `b`=0 throughout. After release: `pending`=0, `busy`=0, `overflow`=0.
- Doubling, FACTOR=2: `a` = 1100_0000.
  - Required: `b` = 1111_0000 and `pending` = 1,2,1,0,0,0,0,0 (value after each edge). `overflow`=0.
- Interleaved, FACTOR=2: `a` = 1010_1000.
  - Required: `b` = 1111_1100. 6 output tokens total. `busy` low from cycle 6.
- FACTOR=3, single token `a` = 1000_0.
  - Required: `b` = 1110_0 and `pending` = 2,1,0,0,0.
- Saturation, FACTOR=2, PENDING_MAX=3: `a` held 1 for 6 cycles, then 0.
  - Required: `pending` = 1,2,3,3,3,3, then 2,1,0.
  - `overflow` rises after the 4th edge and stays 1.
  - `b` = 1 for 9 cycles total.
- Reset mid-drain, FACTOR=2: `a` = 111 to reach `pending`=3, then pulse `rst`=0 for 1 cycle with `a`=0.
  - Required: `b`=0 during reset. `pending`=0 and `b`=0 afterwards. `overflow` stays 0.
